// File: rtl/packet_send_if.sv
// packet_send_if: AXI-Stream byte channel feeding the frame transmitter.
// The master drives payload beats; the slave returns ready.
interface packet_send_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/packet_send.sv
// packet_send: UDP/IPv4 Ethernet frame transmitter on a byte-wide GMII bus.
// Wraps one AXI-Stream payload in preamble, headers, zero pad and CRC32 FCS.
module packet_send #(
    parameter int GMII_WIDTH      = 8,
    parameter int PAYLOAD_WIDTH   = 11,
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int IFG_CYCLES      = 12
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    packet_send_if.slave             s_axis,
    input  logic [15:0]              fpga_port_i,
    input  logic [31:0]              fpga_ip_i,
    input  logic [47:0]              fpga_mac_i,
    input  logic [15:0]              host_port_i,
    input  logic [31:0]              host_ip_i,
    input  logic [47:0]              host_mac_i,
    input  logic [PAYLOAD_WIDTH-1:0] payload_bytes_i,
    output logic [GMII_WIDTH-1:0]    tx_d_o,
    output logic                     tx_en_o,
    output logic                     tx_er_o,
    output logic                     busy_o,
    output logic                     underrun_o
);

    localparam logic [7:0]  PREAMBULE_VAL = 8'h55;
    localparam logic [7:0]  SFD_VAL       = 8'hD5;
    localparam int          HEADER_BYTES  = 42;
    localparam logic [15:0] MIN_PAYLOAD   = 16'd18;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_HDR  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    logic [2:0]               state;
    logic [15:0]              cnt;
    logic [PAYLOAD_WIDTH-1:0] n_q;
    logic [15:0]              fpga_port_q;
    logic [31:0]              fpga_ip_q;
    logic [47:0]              fpga_mac_q;
    logic [15:0]              host_port_q;
    logic [31:0]              host_ip_q;
    logic [47:0]              host_mac_q;
    logic [15:0]              ip_id;
    logic [15:0]              csum_q;
    logic [31:0]              crc;
    logic                     early;
    logic                     tlast_done;

    logic [15:0]                n16;
    logic [15:0]                ip_len;
    logic [15:0]                udp_len;
    logic [335:0]               hdr;
    logic [335:0]               hdr_sh;
    logic [AXIS_DATA_WIDTH-1:0] pay;
    logic [31:0]                fcs;
    logic [31:0]                crc_nx;
    logic                       accept;
    logic                       last_byte;
    logic                       ifg_done;
    logic [7:0]                 byte_nx;
    logic                       en_nx;
    logic                       er_nx;

    function automatic logic [15:0] ip_csum(
        input logic [15:0] len,
        input logic [15:0] id,
        input logic [31:0] src,
        input logic [31:0] dst
    );
        logic [31:0] s;
        s = 32'h4500 + 32'(len) + 32'(id) + 32'h4000 + 32'h4011
          + 32'(src[31:16]) + 32'(src[15:0])
          + 32'(dst[31:16]) + 32'(dst[15:0]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        s = 32'(s[15:0]) + 32'(s[31:16]);
        return ~s[15:0];
    endfunction

    // Reflected CRC32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    assign n16     = 16'(n_q);
    assign ip_len  = 16'd28 + n16;
    assign udp_len = 16'd8 + n16;
    assign pay     = s_axis.tdata;

    assign hdr = {host_mac_q, fpga_mac_q, 16'h0800,
                  16'h4500, ip_len, ip_id, 16'h4000, 16'h4011,
                  csum_q, fpga_ip_q, host_ip_q,
                  fpga_port_q, host_port_q, udp_len, 16'h0000};
    assign hdr_sh = hdr << {cnt[5:0], 3'b000};

    assign fcs       = ~crc;
    assign accept    = s_axis.tvalid && s_axis.tready;
    assign last_byte = (cnt == n16 - 16'd1);
    assign ifg_done  = (cnt >= 16'(IFG_CYCLES - 1))
                    && (tlast_done || (accept && s_axis.tlast));

    always_comb begin
        s_axis.tready = 1'b0;
        unique case (state)
            S_DATA:  s_axis.tready = !early && s_axis.tvalid && (cnt < n16);
            S_IFG:   s_axis.tready = !tlast_done;
            default: s_axis.tready = 1'b0;
        endcase
    end

    always_comb begin
        byte_nx = 8'h00;
        en_nx   = 1'b0;
        er_nx   = 1'b0;
        unique case (state)
            S_PRE: begin
                en_nx   = 1'b1;
                byte_nx = (cnt == 16'd7) ? SFD_VAL : PREAMBULE_VAL;
            end
            S_HDR: begin
                en_nx   = 1'b1;
                byte_nx = hdr_sh[335:328];
            end
            S_DATA: begin
                en_nx = 1'b1;
                if (accept) byte_nx = pay[7:0];
                else        er_nx   = 1'b1;
            end
            S_PAD: en_nx = 1'b1;
            S_FCS: begin
                en_nx   = 1'b1;
                byte_nx = fcs[{cnt[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign crc_nx     = crc_byte(crc, byte_nx);
    assign busy_o     = (state != S_IDLE);
    assign underrun_o = (state == S_FCS) && (cnt == 16'd0) && early;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_d_o  <= '0;
            tx_en_o <= 1'b0;
            tx_er_o <= 1'b0;
        end else begin
            tx_d_o  <= GMII_WIDTH'(byte_nx);
            tx_en_o <= en_nx;
            tx_er_o <= er_nx;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            n_q         <= '0;
            fpga_port_q <= '0;
            fpga_ip_q   <= '0;
            fpga_mac_q  <= '0;
            host_port_q <= '0;
            host_ip_q   <= '0;
            host_mac_q  <= '0;
            ip_id       <= '0;
            csum_q      <= '0;
            crc         <= 32'hFFFFFFFF;
            early       <= 1'b0;
            tlast_done  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (s_axis.tvalid) begin
                        state       <= S_PRE;
                        cnt         <= '0;
                        n_q         <= payload_bytes_i;
                        fpga_port_q <= fpga_port_i;
                        fpga_ip_q   <= fpga_ip_i;
                        fpga_mac_q  <= fpga_mac_i;
                        host_port_q <= host_port_i;
                        host_ip_q   <= host_ip_i;
                        host_mac_q  <= host_mac_i;
                        crc         <= 32'hFFFFFFFF;
                        early       <= 1'b0;
                        tlast_done  <= 1'b0;
                    end
                end
                S_PRE: begin
                    csum_q <= ip_csum(ip_len, ip_id, fpga_ip_q, host_ip_q);
                    if (cnt == 16'd7) begin
                        state <= S_HDR;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_HDR: begin
                    crc <= crc_nx;
                    if (cnt == 16'(HEADER_BYTES - 1)) begin
                        state <= (n16 == 16'd0) ? S_PAD : S_DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    crc <= crc_nx;
                    if (!s_axis.tvalid) early <= 1'b1;
                    if (accept && s_axis.tlast) begin
                        tlast_done <= 1'b1;
                        if (!last_byte) early <= 1'b1;
                    end
                    // cnt keeps counting payload bytes so PAD ends at 18
                    if (last_byte && n16 >= MIN_PAYLOAD) begin
                        state <= S_FCS;
                        cnt   <= '0;
                    end else begin
                        if (last_byte) state <= S_PAD;
                        cnt <= cnt + 16'd1;
                    end
                end
                S_PAD: begin
                    crc <= crc_nx;
                    if (cnt == MIN_PAYLOAD - 16'd1) begin
                        state <= S_FCS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_FCS: begin
                    if (cnt == 16'd3) begin
                        state <= S_IFG;
                        cnt   <= '0;
                        ip_id <= ip_id + 16'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_IFG: begin
                    if (accept && s_axis.tlast) tlast_done <= 1'b1;
                    if (ifg_done) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt < 16'(IFG_CYCLES - 1)) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_send.sv
// tb_packet_send: directed frames checked byte-by-byte against a frame model.
// Literal checks pin lengths, header fields, ids, gaps and underrun pulses.
`timescale 1ns/1ps
module tb_packet_send;

    logic        clk;
    logic        rstn;
    logic [15:0] fpga_port;
    logic [31:0] fpga_ip;
    logic [47:0] fpga_mac;
    logic [15:0] host_port;
    logic [31:0] host_ip;
    logic [47:0] host_mac;
    logic [10:0] payload_bytes;
    logic [7:0]  tx_d;
    logic        tx_en;
    logic        tx_er;
    logic        busy;
    logic        underrun;

    packet_send_if #(.DW(8)) axis ();

    packet_send #(
        .GMII_WIDTH(8), .PAYLOAD_WIDTH(11),
        .AXIS_DATA_WIDTH(8), .IFG_CYCLES(12)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .s_axis(axis.slave),
        .fpga_port_i(fpga_port), .fpga_ip_i(fpga_ip), .fpga_mac_i(fpga_mac),
        .host_port_i(host_port), .host_ip_i(host_ip), .host_mac_i(host_mac),
        .payload_bytes_i(payload_bytes),
        .tx_d_o(tx_d), .tx_en_o(tx_en), .tx_er_o(tx_er),
        .busy_o(busy), .underrun_o(underrun)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- frame model ----------------
    logic [8:0]  exp_q[$];
    int          exp_len[$];
    logic [15:0] m_id;
    logic [7:0]  mb[$];
    logic        me[$];

    function automatic logic [31:0] crc_ref(input logic [31:0] c,
                                            input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic put(input logic [47:0] v, input int nb);
        for (int i = nb - 1; i >= 0; i--) begin
            mb.push_back(v[8*i +: 8]);
            me.push_back(1'b0);
        end
    endtask

    task automatic build_frame(input int n, input int k, input logic [7:0] base);
        logic [31:0] s;
        logic [15:0] w[10];
        logic [15:0] cs;
        logic [31:0] c;
        mb = {};
        me = {};
        w[0] = 16'h4500; w[1] = 16'(28 + n); w[2] = m_id; w[3] = 16'h4000;
        w[4] = 16'h4011; w[5] = 16'h0000;
        w[6] = fpga_ip[31:16]; w[7] = fpga_ip[15:0];
        w[8] = host_ip[31:16]; w[9] = host_ip[15:0];
        s = 0;
        for (int i = 0; i < 10; i++) s += 32'(w[i]);
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        put(host_mac, 6); put(fpga_mac, 6); put(48'h0800, 2);
        put(48'h4500, 2); put(48'(28 + n), 2); put(48'(m_id), 2);
        put(48'h4000, 2); put(48'h4011, 2); put(48'(cs), 2);
        put(48'(fpga_ip), 4); put(48'(host_ip), 4);
        put(48'(fpga_port), 2); put(48'(host_port), 2);
        put(48'(8 + n), 2); put(48'h0, 2);
        for (int i = 0; i < n; i++) begin
            mb.push_back(i < k ? 8'(base + i) : 8'h00);
            me.push_back(i >= k);
        end
        for (int i = n; i < 18; i++) begin
            mb.push_back(8'h00);
            me.push_back(1'b0);
        end
        c = 32'hFFFFFFFF;
        foreach (mb[i]) c = crc_ref(c, mb[i]);
        c = ~c;
        for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        foreach (mb[i]) exp_q.push_back({me[i], mb[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, c[8*i +: 8]});
        exp_len.push_back(8 + 42 + (n > 18 ? n : 18) + 4);
        m_id = m_id + 16'd1;
    endtask

    // ---------------- AXIS source ----------------
    logic [9:0] bq[$];

    initial begin
        logic hs;
        logic cur_gap;
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        axis.tdata  = 8'h00;
        cur_gap = 1'b0;
        forever begin
            @(negedge clk);
            hs = axis.tvalid && axis.tready;
            @(posedge clk);
            #1;
            if ((cur_gap || hs) && bq.size() > 0) bq.delete(0);
            cur_gap = 1'b0;
            if (bq.size() == 0) begin
                axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = 8'h00;
            end else if (bq[0][9]) begin
                axis.tvalid = 1'b0; axis.tlast = 1'b0; cur_gap = 1'b1;
            end else begin
                axis.tvalid = 1'b1;
                axis.tlast  = bq[0][8];
                axis.tdata  = bq[0][7:0];
            end
        end
    end

    task automatic send_frame(input int n, input int beats, input int last_at,
                              input int gap_at, input logic [7:0] base);
        int k;
        k = n;
        if (gap_at >= 0 && gap_at < k) k = gap_at;
        if (last_at + 1 < k) k = last_at + 1;
        if (beats < k) k = beats;
        payload_bytes = 11'(n);
        build_frame(n, k, base);
        for (int i = 0; i < beats; i++) begin
            if (i == gap_at) bq.push_back(10'h200);
            bq.push_back({1'b0, i == last_at, 8'(base + i)});
        end
    endtask

    // ---------------- compare process ----------------
    int          cur = 0;
    int          low = -1;
    int          gap_start = -1;
    int          last_len = 0;
    int          n_und = 0;
    logic [7:0]  fb[0:2047];
    logic [15:0] done_id[$];
    int          done_gap[$];

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                cur = 0;
                low = -1;
            end else begin
                if (underrun) n_und++;
                if (tx_en) begin
                    if (cur == 0) gap_start = low;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL stray_byte: got %h, want none", tx_d);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", cur), {tx_er, tx_d}, 32'(e));
                    end
                    if (cur < 2048) fb[cur] = tx_d;
                    cur++;
                end else if (cur > 0) begin
                    if (exp_len.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL frame_len: got %0d, want no frame", cur);
                    end else begin
                        chk("frame_len", cur, exp_len.pop_front());
                    end
                    last_len = cur;
                    done_id.push_back({fb[26], fb[27]});
                    done_gap.push_back(gap_start);
                    cur = 0;
                    low = 1;
                end else if (low >= 0) begin
                    low++;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input string name);
        int t;
        t = 0;
        while ((busy || bq.size() != 0 || exp_q.size() != 0) && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got busy, want idle", name);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bq = {};
        exp_q = {};
        exp_len = {};
        axis.tvalid = 1'b0;
        m_id = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    function automatic logic [15:0] hdr_sum();
        logic [31:0] s;
        s = 0;
        for (int i = 0; i < 10; i++) s += 32'({fb[22 + 2*i], fb[23 + 2*i]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int u0;
        logic [31:0] c;
        logic [7:0]  s9[9];
        logic [7:0]  orv;
        rstn = 1'b0;
        m_id = 16'd0;
        fpga_port = 16'h1F90; fpga_ip = 32'hC0A80002;
        fpga_mac  = 48'h000A35010203;
        host_port = 16'h2328; host_ip = 32'hC0A80001;
        host_mac  = 48'hFFEEDDCCBBAA;
        payload_bytes = 11'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_d", tx_d, 0);
        chk("rst_tx_er", tx_er, 0);
        chk("rst_tready", axis.tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        rstn = 1'b1;

        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFFFFFF;
        foreach (s9[i]) c = crc_ref(c, s9[i]);
        chk("model_crc_check", ~c, 32'hCBF43926);

        @(posedge clk); #2;
        send_frame(18, 18, 17, -1, 8'h00);
        t = 0;
        while (!axis.tvalid && t < 10) begin @(posedge clk); #2; t++; end
        @(posedge clk); #2;
        chk("start_t1_tx_en", tx_en, 0);
        chk("start_t1_busy", busy, 1);
        @(posedge clk); #2;
        chk("start_t2_tx_en", tx_en, 1);
        chk("start_t2_tx_d", tx_d, 8'h55);
        payload_bytes = 11'd3;
        host_ip = 32'h0A000063;
        wait_done("nominal");
        chk("nom_len", last_len, 72);
        chk("nom_ip_len", {fb[24], fb[25]}, 16'h002E);
        chk("nom_udp_len", {fb[46], fb[47]}, 16'h001A);
        chk("nom_hdr_sum", hdr_sum(), 16'hFFFF);
        chk("nom_first_pay", fb[50], 8'h00);
        chk("nom_last_pay", fb[67], 8'h11);

        send_frame(4, 4, 3, -1, 8'hA0);
        wait_done("pad");
        orv = 8'h00;
        for (int i = 54; i < 68; i++) orv |= fb[i];
        chk("pad_len", last_len, 72);
        chk("pad_ip_len", {fb[24], fb[25]}, 16'h0020);
        chk("pad_last_pay", fb[53], 8'hA3);
        chk("pad_zero", orv, 8'h00);

        do_reset();
        done_id = {};
        done_gap = {};
        send_frame(20, 20, 19, -1, 8'h30);
        send_frame(20, 20, 19, -1, 8'h50);
        wait_done("b2b");
        chk("b2b_frames", done_id.size(), 2);
        if (done_id.size() == 2) begin
            chk("b2b_id0", done_id[0], 16'h0000);
            chk("b2b_id1", done_id[1], 16'h0001);
            chk("b2b_gap", done_gap[1], 13);
        end

        u0 = n_und;
        send_frame(20, 10, 9, -1, 8'h60);
        wait_done("early");
        chk("early_len", last_len, 74);
        chk("early_underrun", n_und - u0, 1);

        u0 = n_und;
        send_frame(20, 20, 19, 5, 8'h70);
        wait_done("gap");
        chk("gap_len", last_len, 74);
        chk("gap_underrun", n_und - u0, 1);

        u0 = n_und;
        send_frame(20, 30, 29, -1, 8'h80);
        t = 0;
        while (!busy && t < 50) begin @(posedge clk); #2; t++; end
        send_frame(18, 18, 17, -1, 8'hC0);
        wait_done("late");
        chk("late_len", last_len, 72);
        chk("late_next_pay", fb[50], 8'hC0);
        chk("late_underrun", n_und - u0, 0);

        send_frame(0, 1, 0, -1, 8'hE0);
        wait_done("n0");
        chk("n0_len", last_len, 72);
        chk("n0_ip_len", {fb[24], fb[25]}, 16'h001C);

        send_frame(20, 20, 19, -1, 8'h10);
        t = 0;
        while (cur < 13 && t < 200) begin @(posedge clk); #2; t++; end
        rstn = 1'b0;
        #1;
        chk("midrst_tx_en", tx_en, 0);
        bq = {};
        exp_q = {};
        exp_len = {};
        axis.tvalid = 1'b0;
        m_id = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk); #2;
        send_frame(18, 18, 17, -1, 8'h20);
        wait_done("midrst");
        chk("midrst_len", last_len, 72);
        chk("midrst_id", {fb[26], fb[27]}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/packet_send.md
# packet_send

UDP/IPv4 Ethernet frame transmitter for the RGMII path, the transmit counterpart of `packet_recv`. It takes one payload packet from an AXI-Stream slave port and builds a complete frame around it: preamble/SFD, Ethernet + IPv4 + UDP header, payload with zero padding, and CRC32 FCS. The frame is driven byte-serially onto the GMII transmit bus, ahead of the RGMII TX PHY adapter.

## Interface
- `GMII_WIDTH`, 8: GMII data width; only 8 is supported.
- `PAYLOAD_WIDTH`, 11: width of the payload byte count.
- `AXIS_DATA_WIDTH`, 8: AXIS data width; must equal `GMII_WIDTH`.
- `IFG_CYCLES`, 12: minimum number of `tx_en_o`-low cycles between frames.
- `clk_i`  in  1  GMII TX clock (125 MHz); the only clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  AXIS_DATA_WIDTH  payload byte.
- `s_axis_tvalid`  in  1  payload byte valid.
- `s_axis_tlast`  in  1  last payload byte of the packet.
- `s_axis_tready`  out  1  payload byte accepted.
- `fpga_port_i` / `fpga_ip_i` / `fpga_mac_i`  in  16/32/48  source UDP port / IP address / MAC address.
- `host_port_i` / `host_ip_i` / `host_mac_i`  in  16/32/48  destination UDP port / IP address / MAC address.
- `payload_bytes_i`  in  PAYLOAD_WIDTH  payload length N in bytes.
- `tx_d_o`  out  GMII_WIDTH  GMII transmit data.
- `tx_en_o`  out  1  GMII transmit enable.
- `tx_er_o`  out  1  GMII transmit error; asserted on underrun bytes.
- `busy_o`  out  1  high in every state other than IDLE.
- `underrun_o`  out  1  one-cycle pulse when a frame ends early (early tlast or tvalid gap).

## Operation
- **States:** IDLE, PREAMBLE_SFD, HEADER, DATA, PAD, FCS, IFG.
- **IDLE → PREAMBLE_SFD:** taken when `s_axis_tvalid`=1.
  - At that transition, latch all address inputs and `payload_bytes_i` (N). Changes to these inputs mid-frame have no effect.
  - Compute the IPv4 checksum before the checksum byte is emitted.
- **PREAMBLE_SFD:** 8 cycles; bytes 0x55 ×7, then 0xD5 (`PREAMBULE_VAL`, `SFD_VAL`).
- **HEADER:** `HEADER_BYTES` (42) cycles. All multi-byte fields are sent MSB first (network order). Fields in wire order:
  - Ethernet: dst = host_mac, src = fpga_mac, EtherType 0x0800.
  - IPv4 fixed fields: 0x45, TOS 0x00, total length = 28+N.
  - IPv4 identification: 16-bit frame counter; reset 0, +1 per frame, wraps at 0xFFFF→0.
  - IPv4 remaining fields: flags/frag 0x4000, TTL 0x40, protocol 0x11, header checksum, src = fpga_ip, dst = host_ip.
  - IPv4 header checksum: one's-complement of the one's-complement 16-bit sum of the 10 header words, with the checksum word taken as 0. End-around carry is folded twice.
  - UDP: src = fpga_port, dst = host_port, length = 8+N, checksum 0x0000.
- **DATA:** N cycles.
  - `s_axis_tready`=1 while the data counter < N and no early-end condition has occurred.
  - Each accepted byte goes to `tx_d_o` on the next cycle.
  - N=0: DATA is skipped.
- **PAD:** entered if N < 18; sends 18−N bytes of 0x00, so the frame is a minimum 64 bytes including FCS.
- **FCS:** 4 bytes.
  - CRC32: polynomial 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Covers header + payload + pad; excludes preamble/SFD.
  - Sent least-significant byte first.
- **IFG:** `tx_en_o`=0 for `IFG_CYCLES` cycles, then IDLE.
  - Drain: while in IFG, if the last frame ended without consuming tlast, `s_axis_tready`=1 and beats are discarded.
  - IFG exits only once tlast has been consumed and the count has elapsed.
- **Early end:** a tvalid=0 gap or early tlast while the data counter < N.
  - Each remaining DATA byte is sent as 0x00 with `tx_er_o`=1; tready stays 0.
  - `underrun_o` pulses once at FCS entry.
  - A tvalid gap leaves the rest of the packet in the source; it is drained in IFG.

## Timing
- **Reset values:** `tx_d_o`=0, `tx_en_o`=0, `tx_er_o`=0, `s_axis_tready`=0, `busy_o`=0, `underrun_o`=0; state IDLE; IP id 0; CRC register 0xFFFFFFFF.
- **Reset mid-frame:** `tx_en_o` drops asynchronously with reset assertion; no FCS is sent.
- **Registered outputs:** `tx_d_o`, `tx_en_o` and `tx_er_o` are registered.
- **Start latency:** if tvalid is sampled 1 in IDLE at cycle t, the first 0x55 appears at t+2.
- **Frame length:** `tx_en_o` is high for 8+42+max(N,18)+4 consecutive cycles, with no gaps.
- **Payload latency:** tready/tvalid handshake at cycle k → that byte is on `tx_d_o` at k+1.
- **Combinational ready:** `s_axis_tready` is combinational from state, counter and `s_axis_tvalid`/`s_axis_tlast` only.
- **Inter-frame gap:** minimum gap between frames is `IFG_CYCLES` cycles of `tx_en_o` low, plus 1 IDLE cycle.

## Test plan
- **Nominal frame:** N=18, bytes 0x00..0x11, tlast on the 18th byte.
  - `tx_en_o` high for 72 cycles; 55×7, D5.
  - IP length 0x002E, UDP length 0x001A.
  - IP header words sum to 0xFFFF; FCS matches the software CRC32.
  - Loopback into `packet_recv` returns 18 identical bytes.
- **Padding:** N=4.
  - 14 bytes of 0x00 follow the payload; IP length 0x0020; `tx_en_o` high for 72 cycles; FCS covers the pad.
- **Back-to-back:** two queued N=20 frames.
  - At least 12 cycles of `tx_en_o` low between them; IP id 0x0000 then 0x0001.
- **Early tlast:** tlast on byte 10 with N=20.
  - Bytes 11–20 are 0x00 with `tx_er_o`=1; one `underrun_o` pulse; frame still 74 cycles.
- **Late tlast:** 30 beats supplied with N=20.
  - 20 bytes sent; 10 beats drained during IFG; the next frame's payload is uncorrupted.
- **Reset mid-frame:** `rstn_i` low at header byte 5.
  - `tx_en_o`=0 immediately; after release, the next frame has IP id 0 and a correct FCS.
